// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART boot loader: UART register map, status bits,
// loader FSM states and the Wishbone request payload.
package uart_loader_pkg;

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 8;

  localparam logic [AW-1:0] UART_STATUS = 24'd0;
  localparam logic [AW-1:0] UART_RXDATA = 24'd1;
  localparam logic [AW-1:0] UART_TXDATA = 24'd2;

  localparam int unsigned RX_AVAIL = 0;
  localparam int unsigned TX_NFULL = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_ADDR,
    ST_LEN,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_MEM_WR,
    ST_ACK_POLL,
    ST_ACK_WR,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } wb_req_t;

  // A frame is in progress in every state except the two waiting states.
  function automatic logic is_busy(input state_e s);
    return !((s == ST_IDLE) || (s == ST_HDR));
  endfunction

endpackage

// File: rtl/wb_single_master.sv
// One-request/one-ack Wishbone master: latches a request, holds cyc/stb and the
// payload stable until ack, then drops the cycle on the following edge.
module wb_single_master
  import uart_loader_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          req_c,
  input  wb_req_t       req,
  input  logic          ack,
  output logic          cyc,
  output logic          stb,
  output logic          we,
  output logic [AW-1:0] adr,
  output logic [DW-1:0] dat,
  output logic          done_c
);

  logic    cyc_q, cyc_d;
  wb_req_t hold_q, hold_d;

  always_comb begin
    cyc_d  = cyc_q;
    hold_d = hold_q;
    if (cyc_q) begin
      if (ack) begin
        cyc_d     = 1'b0;
        hold_d.we = 1'b0;
      end
    end else if (req_c) begin
      cyc_d  = 1'b1;
      hold_d = req;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cyc_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      hold_q <= hold_d;
    end
  end

  assign cyc    = cyc_q;
  assign stb    = cyc_q;
  assign we     = hold_q.we;
  assign adr    = hold_q.adr;
  assign dat    = hold_q.dat;
  assign done_c = cyc_q & ack;

endmodule

// File: rtl/uart_loader.sv
// UART boot loader: receives a header/address/length/data frame over a polled
// UART, writes the words to memory over Wishbone, then answers with ACK_BYTE.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE = 8'hA5,
  parameter logic [7:0] ACK_BYTE = 8'h5A
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  output logic          u_cyc,
  output logic          u_stb,
  output logic          u_we,
  output logic [AW-1:0] u_adr,
  output logic [DW-1:0] u_o_dat,
  input  logic [DW-1:0] u_i_dat,
  input  logic          u_ack,
  output logic          m_cyc,
  output logic          m_stb,
  output logic          m_we,
  output logic [AW-1:0] m_adr,
  output logic [DW-1:0] m_o_dat,
  input  logic          m_ack,
  output logic          o_busy,
  output logic          o_done
);

  state_e        state_q, state_d;
  logic          rd_data_q, rd_data_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] len_q, len_d;
  logic [BW-1:0] hi_q, hi_d;
  logic [BW-1:0] lo_q, lo_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          u_req_c, m_req_c;
  wb_req_t       u_req, m_req;
  logic          u_done_c, m_done_c;
  logic          byte_vld_c;
  logic [BW-1:0] rx_byte_c;
  logic          unused_hi_c;

  assign unused_hi_c = ^u_i_dat[DW-1:BW];

  always_comb begin
    state_d    = state_q;
    rd_data_d  = rd_data_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    len_d      = len_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    u_req_c    = 1'b0;
    u_req      = '0;
    m_req_c    = 1'b0;
    m_req      = '{we: 1'b1, adr: addr_q, dat: {hi_q, lo_q}};
    byte_vld_c = 1'b0;
    rx_byte_c  = u_i_dat[BW-1:0];

    // Byte fetch: poll STATUS until RX_AVAIL, then exactly one RXDATA read.
    if (state_q inside {ST_HDR, ST_ADDR, ST_LEN, ST_DATA_HI, ST_DATA_LO}) begin
      if (!u_cyc) begin
        if ((state_q == ST_HDR) && !i_en) begin
          state_d   = ST_IDLE;
          rd_data_d = 1'b0;
        end else begin
          u_req_c   = 1'b1;
          u_req.adr = rd_data_q ? UART_RXDATA : UART_STATUS;
        end
      end else if (u_done_c) begin
        if (rd_data_q) begin
          rd_data_d  = 1'b0;
          byte_vld_c = 1'b1;
        end else begin
          rd_data_d = u_i_dat[RX_AVAIL];
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (i_en) state_d = ST_HDR;
      end
      ST_HDR: begin
        if (byte_vld_c && (rx_byte_c == HDR_BYTE)) begin
          state_d = ST_ADDR;
          cnt_d   = 2'd0;
        end
      end
      ST_ADDR: begin
        if (byte_vld_c) begin
          addr_d = {addr_q[AW-BW-1:0], rx_byte_c};
          if (cnt_q == 2'd2) begin
            cnt_d   = 2'd0;
            state_d = ST_LEN;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      ST_LEN: begin
        if (byte_vld_c) begin
          len_d = {len_q[BW-1:0], rx_byte_c};
          if (cnt_q == 2'd1) begin
            cnt_d   = 2'd0;
            state_d = (len_d == '0) ? ST_ACK_POLL : ST_DATA_HI;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      ST_DATA_HI: begin
        if (byte_vld_c) begin
          hi_d    = rx_byte_c;
          state_d = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (byte_vld_c) begin
          lo_d    = rx_byte_c;
          state_d = ST_MEM_WR;
        end
      end
      ST_MEM_WR: begin
        if (!m_cyc) begin
          m_req_c = 1'b1;
        end else if (m_done_c) begin
          addr_d  = addr_q + 24'd1;
          len_d   = len_q - 16'd1;
          state_d = (len_q == 16'd1) ? ST_ACK_POLL : ST_DATA_HI;
        end
      end
      ST_ACK_POLL: begin
        if (!u_cyc) begin
          u_req_c   = 1'b1;
          u_req.adr = UART_STATUS;
        end else if (u_done_c && u_i_dat[TX_NFULL]) begin
          state_d = ST_ACK_WR;
        end
      end
      ST_ACK_WR: begin
        if (!u_cyc) begin
          u_req_c   = 1'b1;
          u_req.we  = 1'b1;
          u_req.adr = UART_TXDATA;
          u_req.dat = DW'({8'h00, ACK_BYTE});
        end else if (u_done_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = i_en ? ST_HDR : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = is_busy(state_d);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      rd_data_q <= 1'b0;
      cnt_q     <= 2'd0;
      addr_q    <= '0;
      len_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;

  wb_single_master u_uart_wb (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .req_c  (u_req_c),
    .req    (u_req),
    .ack    (u_ack),
    .cyc    (u_cyc),
    .stb    (u_stb),
    .we     (u_we),
    .adr    (u_adr),
    .dat    (u_o_dat),
    .done_c (u_done_c)
  );

  wb_single_master u_mem_wb (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .req_c  (m_req_c),
    .req    (m_req),
    .ack    (m_ack),
    .cyc    (m_cyc),
    .stb    (m_stb),
    .we     (m_we),
    .adr    (m_adr),
    .dat    (m_o_dat),
    .done_c (m_done_c)
  );

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: behavioural UART and memory slaves, a frame-level
// reference model of the expected memory writes, and per-scenario checks.
module tb_uart_loader;

  typedef logic [39:0] rec_q_t[$];

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_en = 1'b0;
  logic        u_cyc, u_stb, u_we;
  logic [23:0] u_adr;
  logic [15:0] u_o_dat;
  logic [15:0] u_i_dat = 16'h0000;
  logic        u_ack = 1'b0;
  logic        m_cyc, m_stb, m_we;
  logic [23:0] m_adr;
  logic [15:0] m_o_dat;
  logic        m_ack = 1'b0;
  logic        o_busy, o_done;

  always #5 clk = ~clk;

  uart_loader #(.HDR_BYTE(8'hA5), .ACK_BYTE(8'h5A)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_en(i_en),
    .u_cyc(u_cyc), .u_stb(u_stb), .u_we(u_we), .u_adr(u_adr),
    .u_o_dat(u_o_dat), .u_i_dat(u_i_dat), .u_ack(u_ack),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_o_dat(m_o_dat), .m_ack(m_ack),
    .o_busy(o_busy), .o_done(o_done)
  );

  int n_pass = 0;
  int n_chk  = 0;

  // Slave-model state
  logic [7:0]  rx_q[$];
  rec_q_t      tx_log;
  rec_q_t      mem_log;
  int          rx_block = 0;
  logic        tx_nfull = 1'b1;
  int          u_cnt = 0, u_dly = 0;
  int          mem_dly = 0, m_cnt = 0;
  logic [23:0] m_adr_l;
  logic [15:0] m_dat_l;
  int          rd1_cnt = 0, bad_rd = 0, stab_err = 0, overlap = 0;
  int          done_cnt = 0, done_wide = 0, u_act = 0;
  logic        prev_done = 1'b0;

  // Slaves respond on the falling edge so the DUT samples settled values.
  always @(negedge clk) begin
    logic avail;
    avail = (rx_q.size() != 0) && (rx_block == 0);
    if (rx_block > 0) rx_block--;
    if (u_ack) u_ack = 1'b0;
    else if (u_cyc && u_stb) begin
      if (u_cnt < u_dly) u_cnt++;
      else begin
        u_ack = 1'b1;
        u_cnt = 0;
        u_dly = int'($urandom_range(0, 2));
        if (u_we) begin
          tx_log.push_back({u_adr, u_o_dat});
          u_i_dat = 16'h0000;
        end else if (u_adr == 24'd1) begin
          rd1_cnt++;
          if (avail) u_i_dat = {8'h00, rx_q.pop_front()};
          else begin
            bad_rd++;
            u_i_dat = 16'h0000;
          end
        end else begin
          u_i_dat = {14'd0, tx_nfull, avail};
        end
      end
    end else u_cnt = 0;

    if (m_ack) m_ack = 1'b0;
    else if (m_cyc && m_stb) begin
      if (m_cnt == 0) begin
        m_adr_l = m_adr;
        m_dat_l = m_o_dat;
      end else if (m_adr !== m_adr_l || m_o_dat !== m_dat_l) stab_err++;
      if (m_we !== 1'b1) stab_err++;
      if (m_cnt >= mem_dly) begin
        m_ack = 1'b1;
        m_cnt = 0;
        mem_log.push_back({m_adr, m_o_dat});
      end else m_cnt++;
    end else m_cnt = 0;

    if (u_cyc) u_act++;
    if (u_cyc && m_cyc) overlap++;
    if (o_done) begin
      done_cnt++;
      if (prev_done) done_wide++;
    end
    prev_done = o_done;
  end

  // Reference model: word i lands at (base + i) modulo 2^24.
  function automatic rec_q_t exp_writes(input logic [23:0] a, input logic [15:0] w[$]);
    rec_q_t r;
    foreach (w[i]) r.push_back({24'((32'(a) + 32'(i)) % 32'h0100_0000), w[i]});
    return r;
  endfunction

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    tx_log.delete();
    mem_log.delete();
    done_cnt = 0;
  endtask

  task automatic push_frame(input logic [23:0] a, input logic [15:0] w[$]);
    logic [15:0] n;
    n = 16'(w.size());
    rx_q.push_back(8'hA5);
    rx_q.push_back(a[23:16]);
    rx_q.push_back(a[15:8]);
    rx_q.push_back(a[7:0]);
    rx_q.push_back(n[15:8]);
    rx_q.push_back(n[7:0]);
    foreach (w[i]) begin
      rx_q.push_back(w[i][15:8]);
      rx_q.push_back(w[i][7:0]);
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt != 0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    int base;
    i_rst = 1'b1;
    i_en  = 1'b0;
    cyc_wait(3);
    n_chk++; if ({u_cyc, u_stb, u_we} !== 3'b000) $display("FAIL reset_u_strobes got=%b exp=000", {u_cyc, u_stb, u_we}); else n_pass++;
    n_chk++; if ({m_cyc, m_stb, m_we} !== 3'b000) $display("FAIL reset_m_strobes got=%b exp=000", {m_cyc, m_stb, m_we}); else n_pass++;
    n_chk++; if ({o_busy, o_done} !== 2'b00) $display("FAIL reset_status got=%b exp=00", {o_busy, o_done}); else n_pass++;
    i_rst = 1'b0;
    base = u_act;
    cyc_wait(10);
    n_chk++; if (u_act - base != 0) $display("FAIL disabled_no_bus got=%0d exp=0", u_act - base); else n_pass++;
    n_chk++; if (o_busy !== 1'b0) $display("FAIL disabled_busy got=%b exp=0", o_busy); else n_pass++;
  endtask

  task automatic test_basic_frame();
    bit ok;
    logic [7:0] bytes[$] = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    clear_logs();
    i_en = 1'b1;
    foreach (bytes[i]) rx_q.push_back(bytes[i]);
    wait_done(3000, ok);
    cyc_wait(10);
    n_chk++; if (!ok) $display("FAIL basic_done_timeout got=0 exp=1"); else n_pass++;
    n_chk++; if (mem_log.size() != 2) $display("FAIL basic_nwr got=%0d exp=2", mem_log.size()); else n_pass++;
    n_chk++; if (mem_log.size() < 1 || mem_log[0] !== {24'h001000, 16'h1234}) $display("FAIL basic_wr0 got=%h exp=%h", (mem_log.size() > 0) ? mem_log[0] : 40'h0, {24'h001000, 16'h1234}); else n_pass++;
    n_chk++; if (mem_log.size() < 2 || mem_log[1] !== {24'h001001, 16'hABCD}) $display("FAIL basic_wr1 got=%h exp=%h", (mem_log.size() > 1) ? mem_log[1] : 40'h0, {24'h001001, 16'hABCD}); else n_pass++;
    n_chk++; if (tx_log.size() != 1 || tx_log[0] !== {24'd2, 16'h005A}) $display("FAIL basic_ack got_n=%0d got=%h exp=%h", tx_log.size(), (tx_log.size() > 0) ? tx_log[0] : 40'h0, {24'd2, 16'h005A}); else n_pass++;
    n_chk++; if (done_cnt != 1) $display("FAIL basic_done_count got=%0d exp=1", done_cnt); else n_pass++;
  endtask

  task automatic test_discard_len0();
    bit ok;
    logic [7:0] bytes[$] = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00};
    clear_logs();
    foreach (bytes[i]) rx_q.push_back(bytes[i]);
    wait_done(3000, ok);
    cyc_wait(10);
    n_chk++; if (!ok) $display("FAIL len0_done_timeout got=0 exp=1"); else n_pass++;
    n_chk++; if (mem_log.size() != 0) $display("FAIL len0_no_write got=%0d exp=0", mem_log.size()); else n_pass++;
    n_chk++; if (tx_log.size() != 1 || tx_log[0] !== {24'd2, 16'h005A}) $display("FAIL len0_ack got_n=%0d exp_n=1", tx_log.size()); else n_pass++;
    n_chk++; if (rx_q.size() != 0) $display("FAIL len0_consumed got=%0d exp=0", rx_q.size()); else n_pass++;
    n_chk++; if (done_cnt != 1) $display("FAIL len0_done_count got=%0d exp=1", done_cnt); else n_pass++;
  endtask

  task automatic test_addr_wrap();
    bit ok;
    logic [15:0] w[$] = '{16'h1111, 16'h2222};
    clear_logs();
    push_frame(24'hFFFFFF, w);
    wait_done(3000, ok);
    cyc_wait(5);
    n_chk++; if (!ok) $display("FAIL wrap_done_timeout got=0 exp=1"); else n_pass++;
    n_chk++; if (mem_log.size() != 2) $display("FAIL wrap_nwr got=%0d exp=2", mem_log.size()); else n_pass++;
    n_chk++; if (mem_log.size() < 1 || mem_log[0] !== {24'hFFFFFF, 16'h1111}) $display("FAIL wrap_wr0 got=%h exp=%h", (mem_log.size() > 0) ? mem_log[0] : 40'h0, {24'hFFFFFF, 16'h1111}); else n_pass++;
    n_chk++; if (mem_log.size() < 2 || mem_log[1] !== {24'h000000, 16'h2222}) $display("FAIL wrap_wr1 got=%h exp=%h", (mem_log.size() > 1) ? mem_log[1] : 40'h0, {24'h000000, 16'h2222}); else n_pass++;
  endtask

  task automatic test_slow_status();
    bit ok;
    int base;
    logic [23:0] a;
    logic [15:0] w[$];
    rec_q_t exp;
    clear_logs();
    a = 24'($urandom);
    for (int i = 0; i < 3; i++) w.push_back(16'($urandom));
    exp = exp_writes(a, w);
    rx_block = 50;
    mem_dly  = 5;
    base = rd1_cnt;
    push_frame(a, w);
    cyc_wait(45);
    n_chk++; if (rd1_cnt != base) $display("FAIL hold_no_rxread got=%0d exp=0", rd1_cnt - base); else n_pass++;
    wait_done(4000, ok);
    mem_dly = 0;
    n_chk++; if (!ok) $display("FAIL slow_done_timeout got=0 exp=1"); else n_pass++;
    n_chk++; if (mem_log.size() != exp.size()) $display("FAIL slow_nwr got=%0d exp=%0d", mem_log.size(), exp.size()); else n_pass++;
    foreach (exp[i]) begin
      n_chk++; if (i >= mem_log.size() || mem_log[i] !== exp[i]) $display("FAIL slow_wr%0d got=%h exp=%h", i, (i < mem_log.size()) ? mem_log[i] : 40'h0, exp[i]); else n_pass++;
    end
    n_chk++; if (stab_err != 0) $display("FAIL slow_stable got=%0d exp=0", stab_err); else n_pass++;
  endtask

  task automatic test_tx_full();
    bit ok;
    logic [15:0] w[$];
    clear_logs();
    tx_nfull = 1'b0;
    push_frame(24'h123456, w);
    for (int i = 0; i < 2000 && rx_q.size() != 0; i++) cyc_wait(1);
    cyc_wait(20);
    n_chk++; if (tx_log.size() != 0) $display("FAIL txfull_no_write got=%0d exp=0", tx_log.size()); else n_pass++;
    n_chk++; if (o_busy !== 1'b1) $display("FAIL txfull_busy got=%b exp=1", o_busy); else n_pass++;
    tx_nfull = 1'b1;
    wait_done(500, ok);
    cyc_wait(10);
    n_chk++; if (!ok) $display("FAIL txfull_done_timeout got=0 exp=1"); else n_pass++;
    n_chk++; if (tx_log.size() != 1 || tx_log[0] !== {24'd2, 16'h005A}) $display("FAIL txfull_one_ack got_n=%0d exp_n=1", tx_log.size()); else n_pass++;
  endtask

  task automatic test_random_frames();
    bit ok;
    int base;
    for (int k = 0; k < 6; k++) begin
      logic [23:0] a;
      logic [15:0] w[$];
      rec_q_t exp;
      clear_logs();
      a = (k == 2) ? 24'hFFFFFE : 24'($urandom);
      for (int i = 0; i < int'($urandom_range(1, 5)); i++) w.push_back(16'($urandom));
      exp = exp_writes(a, w);
      push_frame(a, w);
      if (k == 3) begin
        cyc_wait(30);
        i_en = 1'b0;
      end
      wait_done(4000, ok);
      n_chk++; if (!ok) $display("FAIL rnd%0d_done_timeout got=0 exp=1", k); else n_pass++;
      n_chk++; if (mem_log.size() != exp.size()) $display("FAIL rnd%0d_nwr got=%0d exp=%0d", k, mem_log.size(), exp.size()); else n_pass++;
      foreach (exp[i]) begin
        n_chk++; if (i >= mem_log.size() || mem_log[i] !== exp[i]) $display("FAIL rnd%0d_wr%0d got=%h exp=%h", k, i, (i < mem_log.size()) ? mem_log[i] : 40'h0, exp[i]); else n_pass++;
      end
      n_chk++; if (tx_log.size() != 1 || tx_log[0] !== {24'd2, 16'h005A}) $display("FAIL rnd%0d_ack got_n=%0d exp_n=1", k, tx_log.size()); else n_pass++;
      if (k == 3) begin
        cyc_wait(1);
        base = u_act;
        cyc_wait(10);
        n_chk++; if (u_act - base != 0 || o_busy !== 1'b0) $display("FAIL en_drop_idle got_act=%0d busy=%b exp=0/0", u_act - base, o_busy); else n_pass++;
        i_en = 1'b1;
      end
    end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    bit seen;
    logic [15:0] w[$] = '{16'hBEEF, 16'h0001};
    logic [15:0] w2[$];
    rec_q_t exp;
    clear_logs();
    mem_dly = 100000;
    push_frame(24'h000200, w);
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      cyc_wait(1);
      if (m_cyc === 1'b1) seen = 1'b1;
    end
    cyc_wait(3);
    n_chk++; if (m_cyc !== 1'b1 || !seen) $display("FAIL rstwr_held got=%b exp=1", m_cyc); else n_pass++;
    i_rst = 1'b1;
    cyc_wait(1);
    n_chk++; if ({m_cyc, m_stb, o_busy, u_cyc} !== 4'b0000) $display("FAIL rstwr_drop got=%b exp=0000", {m_cyc, m_stb, o_busy, u_cyc}); else n_pass++;
    rx_q.delete();
    mem_dly = 0;
    cyc_wait(1);
    i_rst = 1'b0;
    cyc_wait(3);
    clear_logs();
    w2.push_back(16'($urandom));
    w2.push_back(16'($urandom));
    exp = exp_writes(24'h0ABCDE, w2);
    push_frame(24'h0ABCDE, w2);
    wait_done(4000, ok);
    n_chk++; if (!ok) $display("FAIL rstwr_done_timeout got=0 exp=1"); else n_pass++;
    n_chk++; if (mem_log.size() != 2 || mem_log[0] !== exp[0] || mem_log[1] !== exp[1]) $display("FAIL rstwr_reload got_n=%0d exp_n=2", mem_log.size()); else n_pass++;
  endtask

  task automatic test_protocol();
    n_chk++; if (overlap != 0) $display("FAIL both_ports_active got=%0d exp=0", overlap); else n_pass++;
    n_chk++; if (bad_rd != 0) $display("FAIL rxread_without_avail got=%0d exp=0", bad_rd); else n_pass++;
    n_chk++; if (stab_err != 0) $display("FAIL mem_stable got=%0d exp=0", stab_err); else n_pass++;
    n_chk++; if (done_wide != 0) $display("FAIL done_pulse_width got=%0d exp=0", done_wide); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_discard_len0();
    test_addr_wrap();
    test_slow_status();
    test_tx_full();
    test_random_frames();
    test_reset_mid_write();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 SHALL have parameter HDR_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter ACK_BYTE, default 8'h5A, completion byte sent back over UART.
REQ-003 SHALL have port i_clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_en  input  1  loader enable; 0 = hold in IDLE, no bus activity.
REQ-006 SHALL have ports u_cyc, u_stb, u_we  output  1 each  Wishbone master strobes to UART slave.
REQ-007 SHALL have ports u_adr  output  24, u_o_dat  output  16, u_i_dat  input  16, u_ack  input  1  UART-side Wishbone.
REQ-008 SHALL have ports m_cyc, m_stb, m_we  output  1 each; m_adr  output  24; m_o_dat  output  16; m_ack  input  1  memory-side Wishbone (write-only).
REQ-009 SHALL have ports o_busy  output  1 (frame in progress) and o_done  output  1 (one-cycle pulse after ACK_BYTE accepted).

Function
REQ-010 Frame SHALL be: HDR_BYTE, addr[23:16], addr[15:8], addr[7:0], len[15:8], len[7:0], then len data words, each high byte first.
REQ-011 Every UART byte read SHALL be: poll u_adr=0 until u_i_dat[0]=1, then one read at u_adr=1 and take u_i_dat[7:0]; addr 1 SHALL never be read while bit0=0.
REQ-012 Wishbone cycles SHALL assert cyc and stb together, hold adr/dat/we stable until ack, and deassert the cycle after ack is sampled; at most one cycle outstanding per port, never both ports active at once.
REQ-013 FSM states: IDLE, HDR, ADDR (3 bytes), LEN (2 bytes), DATA_HI, DATA_LO, MEM_WR, ACK_POLL, ACK_WR, DONE.
REQ-014 IDLE->HDR when i_en=1; in HDR a byte != HDR_BYTE SHALL be discarded and HDR retained.
REQ-015 LEN=0 SHALL go directly from LEN to ACK_POLL with no memory write.
REQ-016 MEM_WR SHALL write {hi,lo} to m_adr=current address with m_we=1; on m_ack address += 1 (24-bit wrap, FFFFFF->000000) and remaining length -= 1.
REQ-017 After MEM_WR, remaining>0 -> DATA_HI, else ACK_POLL.
REQ-018 ACK_POLL SHALL read u_adr=0 until u_i_dat[1]=1 (tx not full), then ACK_WR writes ACK_BYTE to u_adr=2 with u_we=1.
REQ-019 DONE SHALL pulse o_done for exactly one cycle and return to IDLE (or HDR if i_en=1).
REQ-020 o_busy SHALL be 1 in every state except IDLE and HDR.
REQ-021 i_en falling mid-frame SHALL NOT abort: frame completes, then IDLE.
REQ-022 u_o_dat upper byte SHALL be 0 on the ACK write.

Reset
REQ-023 On i_rst: state=IDLE; all cyc/stb/we=0; o_busy=0; o_done=0; address and length counters=0; reset mid-cycle SHALL drop cyc/stb the following cycle regardless of ack.
REQ-024 Reset SHALL take priority over all other conditions in the same cycle.

Structure
REQ-025 Shared package SHALL hold UART register addresses (STATUS=0, RXDATA=1, TXDATA=2), status bit positions (RX_AVAIL=0, TX_NFULL=1), and the FSM state enum.
REQ-026 One sub-module SHALL be used: wb_single_master (one-request/one-ack Wishbone cycle generator), instantiated twice (UART port, memory port).

Verification
REQ-027 Frame A5 00 10 00 00 02 12 34 AB CD -> memory writes 0x1234@0x001000, 0xABCD@0x001001; then UART write 0x005A@2; o_done one pulse.
REQ-028 Bytes 00 FF A5 00 00 05 00 00 -> first two discarded; no memory write; ACK sent; o_done pulses.
REQ-029 Frame addr FFFFFF, len 2, data 1111 2222 -> writes 0x1111@FFFFFF, 0x2222@000000.
REQ-030 Status bit0 held 0 for 50 cycles then 1 -> zero reads at addr 1 during hold; m_ack delayed 5 cycles -> m_stb held with stable adr/dat throughout.
REQ-031 Status bit1=0 for 20 cycles in ACK_POLL -> no write to addr 2 until bit1=1, then exactly one.
REQ-032 i_rst asserted during MEM_WR with m_ack=0 -> next cycle m_cyc=m_stb=0, o_busy=0, state IDLE; next frame loads correctly.
